// File: rtl/nic_pkg.sv
// Shared constants for the NIC endpoint: PE register map and packet field positions.
// Bit 0 is the MSB of every packet and register word.
package nic_pkg;

    localparam logic [1:0] INPUT_BUFFER  = 2'b00;
    localparam logic [1:0] INPUT_STATUS  = 2'b01;
    localparam logic [1:0] OUTPUT_BUFFER = 2'b10;
    localparam logic [1:0] OUTPUT_STATUS = 2'b11;

    localparam int PKT_VC_POS   = 0;
    localparam int PKT_DIR_POS  = 1;
    localparam int PKT_HOP_MSB  = 8;
    localparam int PKT_HOP_LSB  = 15;
    localparam int PKT_SRC_MSB  = 16;
    localparam int PKT_SRC_LSB  = 31;
    localparam int PKT_DATA_MSB = 32;
    localparam int PKT_DATA_LSB = 63;

endpackage

// File: rtl/nic_slot.sv
// One-entry packet buffer with a full flag. Load wins over unload on the same edge;
// the caller only asserts load while the slot is empty.
module nic_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [0:W-1] i_data,
    input  logic         i_unload,
    output logic         o_full,
    output logic [0:W-1] o_data
);

    logic         r_full;
    logic [0:W-1] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (i_unload) begin
                r_full <= 1'b0;
            end
            if (i_load) begin
                r_full <= 1'b1;
                r_data <= i_data;
            end
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule

// File: rtl/nic_endpoint.sv
// Network interface between one PE register port and one gold_ring router port.
// Holds one outbound and one inbound packet; sends are gated by the router's VC polarity.
module nic_endpoint
    import nic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:1]            addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di
);

    logic                  w_out_full;
    logic [0:DATA_WIDTH-1] w_out_data;
    logic                  w_in_full;
    logic [0:DATA_WIDTH-1] w_in_data;
    logic                  w_pe_read;
    logic                  w_out_load;
    logic                  w_send;
    logic                  w_in_load;
    logic                  w_in_unload;

    // Router handshake: a packet moves on any rising edge where the strobe (net_so / net_si)
    // and the receiver's ready (net_ro / net_ri) are both high; ready never depends on strobe.
    assign w_pe_read   = nicEn & ~nicWrEn;
    assign w_out_load  = nicEn & nicWrEn & (addr == OUTPUT_BUFFER) & ~w_out_full;
    assign w_send      = reset & w_out_full & net_ro & (w_out_data[VC_BIT] == net_polarity);
    assign w_in_load   = net_si & net_ri;
    assign w_in_unload = w_pe_read & (addr == INPUT_BUFFER);

    assign net_so = w_send;
    assign net_do = w_send ? w_out_data : '0;
    assign net_ri = reset & ~w_in_full;

    nic_slot #(.W(DATA_WIDTH)) u_out_slot (
        .clk      (clk),
        .rst_n    (reset),
        .i_load   (w_out_load),
        .i_data   (d_in),
        .i_unload (w_send),
        .o_full   (w_out_full),
        .o_data   (w_out_data)
    );

    nic_slot #(.W(DATA_WIDTH)) u_in_slot (
        .clk      (clk),
        .rst_n    (reset),
        .i_load   (w_in_load),
        .i_data   (net_di),
        .i_unload (w_in_unload),
        .o_full   (w_in_full),
        .o_data   (w_in_data)
    );

    // Reads of the output buffer return zero; buffer reads do not check the full flag.
    always_comb begin
        d_out = '0;
        if (reset && w_pe_read) begin
            case (addr)
                INPUT_BUFFER:  d_out = w_in_data;
                INPUT_STATUS:  d_out = {{(DATA_WIDTH-1){1'b0}}, w_in_full};
                OUTPUT_STATUS: d_out = {{(DATA_WIDTH-1){1'b0}}, w_out_full};
                default:       d_out = '0;
            endcase
        end
    end

endmodule
